// File: rtl/conv_out_collector.sv
// Output collector for the streaming KxK convolver: tracks pixel raster position, keeps valid-window
// results, buffers them in a registered valid/ready FIFO. Optional ReLU on write via CONV_OUT_RELU_EN.
module conv_out_collector #(
  parameter int unsigned N          = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned K_SIZE     = 3,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LAT        = 1,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DATA_WIDTH-1:0]        conv_i,
  output logic                         m_valid,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic                         frame_done,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned WW = DATA_WIDTH + 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           keep_c;
  logic           last_c;
  logic [LAT-1:0] d_en;
  logic [LAT-1:0] d_keep;
  logic [LAT-1:0] d_last;

  logic [WW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [LW-1:0]  count_nxt;
  logic           push_c, pop_c, full_c, accept_c, drop_c;
  logic [DATA_WIDTH-1:0] wdata_c;
  logic [WW-1:0]  head_c;

  assign keep_c = (row >= RW'(K_SIZE - 1)) && (col >= CW'(K_SIZE - 1));
  assign last_c = (row == RW'(ROWS - 1)) && (col == CW'(N - 1));

  // Raster position of the next strobed pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col == CW'(N - 1)) begin
        col <= '0;
        row <= (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Align per-pixel flags with the convolver result latency
  always_ff @(posedge clk) begin
    if (rst) begin
      d_en   <= '0;
      d_keep <= '0;
      d_last <= '0;
    end else begin
      d_en[0]   <= en;
      d_keep[0] <= en && keep_c;
      d_last[0] <= en && last_c;
      for (int i = 1; i < int'(LAT); i++) begin
        d_en[i]   <= d_en[i-1];
        d_keep[i] <= d_keep[i-1];
        d_last[i] <= d_last[i-1];
      end
    end
  end

`ifdef CONV_OUT_RELU_EN
  assign wdata_c = conv_i[DATA_WIDTH-1] ? '0 : conv_i;
`else
  assign wdata_c = conv_i;
`endif

  assign push_c   = d_en[LAT-1] && d_keep[LAT-1];
  assign pop_c    = m_valid && m_ready;
  assign full_c   = (level == LW'(DEPTH));
  assign accept_c = push_c && (!full_c || pop_c);
  assign drop_c   = push_c && full_c && !pop_c;

  // Next FIFO state; head forwards the write word when it lands on an otherwise empty queue
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = level;
    if (accept_c) wr_ptr_nxt = wr_ptr + AW'(1);
    if (pop_c)    rd_ptr_nxt = rd_ptr + AW'(1);
    if (accept_c && !pop_c)      count_nxt = level + LW'(1);
    else if (!accept_c && pop_c) count_nxt = level - LW'(1);
    head_c = mem[rd_ptr_nxt];
    if (accept_c && (wr_ptr == rd_ptr_nxt)) head_c = {d_last[LAT-1], wdata_c};
  end

  always_ff @(posedge clk) begin
    if (accept_c) mem[wr_ptr] <= {d_last[LAT-1], wdata_c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      level      <= count_nxt;
      m_valid    <= (count_nxt != '0);
      if (count_nxt != '0) begin
        m_last <= head_c[WW-1];
        m_data <= head_c[DATA_WIDTH-1:0];
      end
      frame_done <= push_c && d_last[LAT-1];
      overflow   <= overflow || drop_c;
    end
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Scoreboard bench for conv_out_collector: 4x4 frames, K=3, LAT=1; a DEPTH=2 instance covers overflow.
module tb_conv_out_collector;

  logic        clk = 1'b0;
  logic        rst, rst_s, en, m_ready, m_ready_s;
  logic [15:0] conv_i;
  logic        m_valid, m_last, frame_done, overflow;
  logic [15:0] m_data;
  logic [3:0]  level;
  logic        m_valid_s, m_last_s, frame_done_s, overflow_s;
  logic [15:0] m_data_s;
  logic [1:0]  level_s;

  conv_out_collector #(.N(4), .ROWS(4), .K_SIZE(3), .DATA_WIDTH(16), .LAT(1), .DEPTH(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .conv_i(conv_i), .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_ready(m_ready), .frame_done(frame_done), .overflow(overflow), .level(level));

  conv_out_collector #(.N(4), .ROWS(4), .K_SIZE(3), .DATA_WIDTH(16), .LAT(1), .DEPTH(2)) u_small (
    .clk(clk), .rst(rst_s), .en(en), .conv_i(conv_i), .m_valid(m_valid_s), .m_data(m_data_s),
    .m_last(m_last_s), .m_ready(m_ready_s), .frame_done(frame_done_s), .overflow(overflow_s),
    .level(level_s));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic l; } exp_t;
  exp_t q[$];

  int n_vec = 0, n_bad = 0;
  int pops = 0, lasts = 0, dones = 0, dones_s = 0;
  int pix = 0;
  bit prev_en = 1'b0;
  logic [15:0] prev_val = '0;
  logic [15:0] vals [16];
  logic [15:0] ev   [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done) dones++;
      if (m_valid && m_ready) begin
        pops++;
        if (m_last) lasts++;
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL pop_unexpected: got %0h expected no beat", m_data);
        end else begin
          e = q.pop_front();
          chk("pop_data", 32'(m_data), 32'(e.d));
          chk("pop_last", 32'(m_last), 32'(e.l));
        end
      end
    end
    if (!rst_s && frame_done_s) dones_s++;
  end

  function automatic bit kept(input int p);
    return (p == 10) || (p == 11) || (p == 14) || (p == 15);
  endfunction

  // One clock: conv_i carries the result for the pixel strobed one cycle earlier
  task automatic step(input bit e, input logic [15:0] v);
    conv_i   = prev_en ? prev_val : 16'($urandom);
    en       = e;
    prev_en  = e;
    prev_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int gap);
    repeat (gap) step(1'b0, 16'h0);
    if (kept(pix)) q.push_back('{d: ev[pix], l: (pix == 15)});
    step(1'b1, vals[pix]);
    pix = (pix + 1) % 16;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0);
  endtask

  task automatic reset_main();
    rst = 1'b1;
    prev_en = 1'b0;
    pix = 0;
    idle(2);
    rst = 1'b0;
  endtask

  int p0, l0, d0;

  initial begin
    rst = 1'b1; rst_s = 1'b1; en = 1'b0; m_ready = 1'b1; m_ready_s = 1'b0; conv_i = '0;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 16'(4096 + i * 273);
      ev[i]   = vals[i];
    end
    reset_main();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_level", 32'(level), 0);

    // Single frame, always ready
    p0 = pops; l0 = lasts; d0 = dones;
    repeat (16) pixel(0);
    idle(4);
    chk("t1_pops", 32'(pops - p0), 4);
    chk("t1_lasts", 32'(lasts - l0), 1);
    chk("t1_dones", 32'(dones - d0), 1);
    chk("t1_overflow", 32'(overflow), 0);
    chk("t1_level", 32'(level), 0);

    // Backpressure for the whole frame, then drain
    m_ready = 1'b0;
    p0 = pops;
    repeat (16) pixel(0);
    idle(4);
    chk("t2_level_full", 32'(level), 4);
    chk("t2_m_valid", 32'(m_valid), 1);
    chk("t2_no_pops", 32'(pops - p0), 0);
    m_ready = 1'b1;
    idle(6);
    chk("t2_pops", 32'(pops - p0), 4);
    chk("t2_level_empty", 32'(level), 0);
    chk("t2_m_valid_low", 32'(m_valid), 0);

    // DEPTH=2 instance stalled: two stored, last two dropped
    rst_s = 1'b0;
    m_ready_s = 1'b0;
    repeat (16) pixel(0);
    idle(4);
    chk("t3_level", 32'(level_s), 2);
    chk("t3_overflow", 32'(overflow_s), 1);
    chk("t3_m_valid", 32'(m_valid_s), 1);
    chk("t3_frame_done", 32'(dones_s), 1);
    chk("t3_head0", 32'(m_data_s), 32'(vals[10]));
    chk("t3_head0_last", 32'(m_last_s), 0);
    m_ready_s = 1'b1;
    idle(1);
    chk("t3_head1", 32'(m_data_s), 32'(vals[11]));
    chk("t3_head1_last", 32'(m_last_s), 0);
    idle(1);
    chk("t3_drained", 32'(m_valid_s), 0);
    chk("t3_overflow_held", 32'(overflow_s), 1);
    rst_s = 1'b1;
    idle(1);
    chk("t3_overflow_cleared", 32'(overflow_s), 0);

    // en every third cycle with junk on idle conv_i
    p0 = pops; l0 = lasts; d0 = dones;
    repeat (16) pixel(2);
    idle(4);
    chk("t4_pops", 32'(pops - p0), 4);
    chk("t4_lasts", 32'(lasts - l0), 1);
    chk("t4_dones", 32'(dones - d0), 1);

    // Reset mid-frame, then a clean frame
    repeat (7) pixel(0);
    reset_main();
    chk("t5_level_after_rst", 32'(level), 0);
    chk("t5_valid_after_rst", 32'(m_valid), 0);
    p0 = pops; l0 = lasts; d0 = dones;
    repeat (16) pixel(0);
    idle(4);
    chk("t5_pops", 32'(pops - p0), 4);
    chk("t5_lasts", 32'(lasts - l0), 1);
    chk("t5_dones", 32'(dones - d0), 1);

    // Negative and positive samples through the optional ReLU
    vals[10] = 16'hFFE0;
    vals[11] = 16'h0020;
`ifdef CONV_OUT_RELU_EN
    ev[10] = 16'h0000;
`else
    ev[10] = 16'hFFE0;
`endif
    ev[11] = 16'h0020;
    p0 = pops;
    repeat (16) pixel(0);
    idle(4);
    chk("t6_pops", 32'(pops - p0), 4);
    vals[10] = 16'(4096 + 10 * 273);
    vals[11] = 16'(4096 + 11 * 273);
    ev[10] = vals[10];
    ev[11] = vals[11];

    // Two frames back to back
    p0 = pops; l0 = lasts; d0 = dones;
    repeat (32) pixel(0);
    idle(4);
    chk("t7_pops", 32'(pops - p0), 8);
    chk("t7_lasts", 32'(lasts - l0), 2);
    chk("t7_dones", 32'(dones - d0), 2);
    chk("t7_overflow", 32'(overflow), 0);

    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
